pc_sequencer: RTL

Program-counter and fetch sequencer; it consumes the branch-taken select (pc_alu_sel), the jump controls and the immediate produced by the decode/branch logic. It owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. It presents the fetched instruction to the decoders and advances the PC when the core signals completion. It also counts retired instructions and flags fetch timeouts.

---
 rtl/pc_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: fetches over imem req/ack, holds the instruction until retired.
// Optional PC_MISALIGN_TRAP_EN: trap to ERR on a misaligned next PC instead of clearing bits [1:0].
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 16,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      insn_in,
  output logic [31:0]      insn_out,
  output logic             insn_valid,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  input  logic             step,
  input  logic             stall,
  input  logic             pc_alu_sel,
  input  logic             jump,
  input  logic             jalr,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  output logic             fetch_err,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {FETCH, EXEC, ERR} state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  state_t           state;
  logic [31:0]      pc;
  logic [TW-1:0]    tcnt;
  logic [31:0]      target;
  logic [31:0]      next_pc;
  logic             advance;

  always_comb begin
    target = pc + 32'd4;
    if (jalr)
      target = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (jump || pc_alu_sel)
      target = pc + imm;
`ifdef PC_MISALIGN_TRAP_EN
    next_pc = target;
`else
    next_pc = target & 32'hFFFF_FFFC;
`endif
  end

  assign advance   = (state == EXEC) && step && !stall;
  // Gated by rst_n so the request drops the instant reset is asserted.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign pc_plus4  = pc + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_reg;
  assign misalign_err = misalign_reg;
`else
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      tcnt       <= '0;
      insn_out   <= '0;
      insn_valid <= 1'b0;
      fetch_err  <= 1'b0;
      retired    <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          // An ack in the expiring cycle still completes the fetch.
          if (imem_ack) begin
            insn_out   <= insn_in;
            insn_valid <= 1'b1;
            tcnt       <= '0;
            state      <= EXEC;
          end else if (tcnt == TCNT_LAST) begin
            fetch_err <= 1'b1;
            tcnt      <= '0;
            state     <= ERR;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        EXEC: begin
          if (advance) begin
            pc         <= next_pc;
            insn_valid <= 1'b0;
            retired    <= retired + CNT_W'(1);
`ifdef PC_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              misalign_reg <= 1'b1;
              state        <= ERR;
            end else begin
              state <= FETCH;
            end
`else
            state <= FETCH;
`endif
          end
        end
        ERR: begin
          insn_valid <= 1'b0;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule
